seq_pattern_detector: RTL

Parametrised serial sequence detector. A WIDTH-bit target pattern and an active length are loaded from the board switches; the block then monitors a qualified serial bit stream. On each complete occurrence of the pattern it emits a one-cycle match pulse and increments a saturating match counter. The block sits between the switch and button front end and the LED and seven-segment display logic. It is the generalised successor of the fixed 10-bit switch-capture register, adding variable length, stream detection, overlap mode and occurrence counting.

---
 rtl/seq_pattern_detector.sv | 91 +++++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: variable-length target, overlap mode, saturating match counter.
// Latency 1 clk from completing bit to match pulse; no backpressure, a bit is taken on every i_bit_valid.
module seq_pattern_detector #(
   parameter int WIDTH = 10,
   parameter int LW    = $clog2(WIDTH + 1),
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_pattern_in,
   input  logic [LW-1:0]    i_len_in,
   input  logic             i_overlap,
   input  logic             i_bit_in,
   input  logic             i_bit_valid,
   output logic [WIDTH-1:0] o_pattern,
   output logic [LW-1:0]    o_len,
   output logic             o_armed,
   output logic             o_match,
   output logic [CNT_W-1:0] o_match_count
);

   typedef enum logic {S_IDLE, S_ARMED} state_t;

   localparam logic [LW-1:0]    LEN_MAX = LW'(WIDTH);
   localparam logic [LW-1:0]    ONE_L   = LW'(1);
   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_pattern;
   logic [LW-1:0]    r_len;
   logic [WIDTH-1:0] r_history;
   logic [LW-1:0]    r_fill;
   logic             r_match;
   logic [CNT_W-1:0] r_count;

   logic [LW-1:0]    w_len_clamped;
   logic [WIDTH-1:0] w_hist_next;
   logic [LW-1:0]    w_fill_inc;
   logic [WIDTH-1:0] w_mask;
   logic             w_accept;
   logic             w_hit;

   assign w_len_clamped = (i_len_in == '0 || i_len_in > LEN_MAX) ? LEN_MAX : i_len_in;
   assign w_hist_next   = {r_history[WIDTH-2:0], i_bit_in};
   assign w_fill_inc    = (r_fill < r_len) ? r_fill + ONE_L : r_fill;
   // Shift wraps to zero when r_len == WIDTH, so the subtraction yields all ones.
   assign w_mask        = (ONE_W << r_len) - ONE_W;
   assign w_accept      = (r_state == S_ARMED) && i_bit_valid && !i_load;
   assign w_hit         = (w_fill_inc == r_len) && (((w_hist_next ^ r_pattern) & w_mask) == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_pattern <= '0;
         r_len     <= '0;
         r_history <= '0;
         r_fill    <= '0;
         r_match   <= 1'b0;
         r_count   <= '0;
      end else begin
         r_match <= 1'b0;
         if (i_load) begin
            r_state   <= S_ARMED;
            r_pattern <= i_pattern_in;
            r_len     <= w_len_clamped;
            r_history <= '0;
            r_fill    <= '0;
            r_count   <= '0;
         end else if (w_accept) begin
            r_history <= w_hist_next;
            if (w_hit) begin
               r_match <= 1'b1;
               if (r_count != '1)
                  r_count <= r_count + ONE_C;
               r_fill <= i_overlap ? w_fill_inc : '0;
            end else begin
               r_fill <= w_fill_inc;
            end
         end
      end
   end

   assign o_pattern     = r_pattern;
   assign o_len         = r_len;
   assign o_armed       = (r_state == S_ARMED);
   assign o_match       = r_match;
   assign o_match_count = r_count;

endmodule
